// File: rtl/maple_link_ctrl.sv
// rtl/maple_link_ctrl.sv - Maple Bus transaction sequencer: guard, TX, turnaround, RX window, status
// Optional per-status DONE counters are built when MAPLE_LINK_STATS_EN is defined.
`timescale 1ns/1ps
module maple_link_ctrl #(
    parameter int GUARD_CYCLES = 64,
    parameter int TURN_CYCLES  = 16,
    parameter int TIMEOUT_W    = 20
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 ctrl_enable,
    input  logic                 frame_avail,
    input  logic                 rx_expect,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic                 sdcka_in,
    input  logic                 sdckb_in,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 line_oe,
    output logic                 rx_arm,
    input  logic                 rx_busy,
    input  logic                 rx_done,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status
`ifdef MAPLE_LINK_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [15:0]          stat_ok,
    output logic [15:0]          stat_timeout,
    output logic [15:0]          stat_abort
`endif
);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int PW = ($clog2(TURN_CYCLES + 1) > 4) ? $clog2(TURN_CYCLES + 1) : 4;
    localparam logic [GW-1:0]        GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [PW-1:0]        TURN_LAST  = PW'(TURN_CYCLES - 1);
    localparam logic [PW-1:0]        TX_LAST    = PW'(7);
    localparam logic [TIMEOUT_W-1:0] TO_ONE     = TIMEOUT_W'(1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_TXONLY  = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_GUARD, S_LAUNCH, S_TX, S_TURN, S_RX_WAIT, S_RX, S_DONE
    } state_t;

    state_t               r_state;
    logic [GW-1:0]        r_guard_cnt;
    logic [PW-1:0]        r_phase_cnt;
    logic [TIMEOUT_W-1:0] r_to_cnt;
    logic [TIMEOUT_W-1:0] r_timeout;
    logic                 r_tx_seen;
    logic                 r_rx_busy_d;
    logic                 r_rx_expect;
    logic [1:0]           r_status;

    state_t               w_state_nxt;
    logic [GW-1:0]        w_guard_nxt;
    logic [PW-1:0]        w_phase_nxt;
    logic [TIMEOUT_W-1:0] w_to_nxt;
    logic [TIMEOUT_W-1:0] w_timeout_nxt;
    logic                 w_tx_seen_nxt;
    logic                 w_rx_expect_nxt;
    logic [1:0]           w_status_nxt;
    logic [PW-1:0]        w_phase_inc;

    assign w_phase_inc = (r_phase_cnt == '1) ? r_phase_cnt : r_phase_cnt + PW'(1);
    assign status      = r_status;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_guard_cnt <= '0;
            r_phase_cnt <= '0;
            r_to_cnt    <= '0;
            r_timeout   <= '0;
            r_tx_seen   <= 1'b0;
            r_rx_busy_d <= 1'b0;
            r_rx_expect <= 1'b0;
            r_status    <= ST_OK;
        end else begin
            r_state     <= w_state_nxt;
            r_guard_cnt <= w_guard_nxt;
            r_phase_cnt <= w_phase_nxt;
            r_to_cnt    <= w_to_nxt;
            r_timeout   <= w_timeout_nxt;
            r_tx_seen   <= w_tx_seen_nxt;
            r_rx_busy_d <= rx_busy;
            r_rx_expect <= w_rx_expect_nxt;
            r_status    <= w_status_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_guard_nxt     = '0;
        w_phase_nxt     = '0;
        w_to_nxt        = '0;
        w_timeout_nxt   = r_timeout;
        w_tx_seen_nxt   = 1'b0;
        w_rx_expect_nxt = r_rx_expect;
        w_status_nxt    = r_status;
        tx_start        = 1'b0;
        line_oe         = 1'b0;
        rx_arm          = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;

        // Outputs decode purely from state, so line_oe and rx_arm can never overlap.
        case (r_state)
            S_LAUNCH:        begin line_oe = 1'b1; tx_start = 1'b1; busy = 1'b1; end
            S_TX:            begin line_oe = 1'b1; busy = 1'b1; end
            S_TURN:          busy = 1'b1;
            S_RX_WAIT, S_RX: begin rx_arm = 1'b1; busy = 1'b1; end
            S_DONE:          begin done = 1'b1; busy = 1'b1; end
            default:         ;
        endcase

        if (!ctrl_enable) begin
            case (r_state)
                S_LAUNCH, S_TX, S_TURN, S_RX_WAIT, S_RX: begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_ABORT;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: if (frame_avail) w_state_nxt = S_GUARD;
                S_GUARD: begin
                    if (sdcka_in && sdckb_in) begin
                        if (r_guard_cnt == GUARD_LAST) w_state_nxt = S_LAUNCH;
                        else                           w_guard_nxt = r_guard_cnt + GW'(1);
                    end
                end
                S_LAUNCH: begin
                    w_rx_expect_nxt = rx_expect;
                    w_timeout_nxt   = timeout_cycles;
                    w_state_nxt     = S_TX;
                end
                S_TX: begin
                    w_tx_seen_nxt = r_tx_seen | tx_busy;
                    if (r_tx_seen && !tx_busy) begin
                        w_state_nxt = S_TURN;
                    end else if (!r_tx_seen && !tx_busy && r_phase_cnt == TX_LAST) begin
                        w_state_nxt  = S_DONE;
                        w_status_nxt = ST_ABORT;
                    end else begin
                        w_phase_nxt = w_phase_inc;
                    end
                end
                S_TURN: begin
                    if (r_phase_cnt == TURN_LAST) begin
                        if (r_rx_expect) begin
                            w_state_nxt = S_RX_WAIT;
                        end else begin
                            w_state_nxt  = S_DONE;
                            w_status_nxt = ST_TXONLY;
                        end
                    end else begin
                        w_phase_nxt = w_phase_inc;
                    end
                end
                S_RX_WAIT: begin
                    if (rx_busy) begin
                        w_state_nxt = S_RX;
                        w_to_nxt    = r_to_cnt;
                    end else if (r_timeout == '0 || r_to_cnt == r_timeout - TO_ONE) begin
                        w_state_nxt  = S_DONE;
                        w_status_nxt = ST_TIMEOUT;
                    end else begin
                        w_to_nxt = (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + TO_ONE;
                    end
                end
                S_RX: begin
                    w_to_nxt = r_to_cnt;
                    if (rx_done) begin
                        w_state_nxt  = S_DONE;
                        w_status_nxt = ST_OK;
                    end else if (r_rx_busy_d && !rx_busy) begin
                        w_state_nxt  = S_DONE;
                        w_status_nxt = ST_TIMEOUT;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef MAPLE_LINK_STATS_EN
    always_ff @(posedge aclk) begin
        if (areset || stat_clr) begin
            stat_ok      <= '0;
            stat_timeout <= '0;
            stat_abort   <= '0;
        end else if (r_state == S_DONE) begin
            case (r_status)
                ST_OK:      if (stat_ok != 16'hFFFF)      stat_ok      <= stat_ok + 16'd1;
                ST_TIMEOUT: if (stat_timeout != 16'hFFFF) stat_timeout <= stat_timeout + 16'd1;
                ST_ABORT:   if (stat_abort != 16'hFFFF)   stat_abort   <= stat_abort + 16'd1;
                default:    ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_maple_link_ctrl.sv
// tb/tb_maple_link_ctrl.sv - directed and randomized transactions checked against a timing reference model
`timescale 1ns/1ps
module tb_maple_link_ctrl;
    localparam int GUARD = 64;
    localparam int TURN  = 16;
    localparam int TW    = 20;

    logic          aclk = 1'b0;
    logic          areset, ctrl_enable, frame_avail, rx_expect;
    logic [TW-1:0] timeout_cycles;
    logic          sdcka_in, sdckb_in, tx_busy, rx_busy, rx_done;
    logic          tx_start, line_oe, rx_arm, busy, done;
    logic [1:0]    status;
`ifdef MAPLE_LINK_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_ok, stat_timeout, stat_abort;
    int            e_ok = 0, e_to = 0, e_ab = 0;
`endif

    maple_link_ctrl #(.GUARD_CYCLES(GUARD), .TURN_CYCLES(TURN), .TIMEOUT_W(TW)) dut (
        .aclk(aclk), .areset(areset), .ctrl_enable(ctrl_enable), .frame_avail(frame_avail),
        .rx_expect(rx_expect), .timeout_cycles(timeout_cycles), .sdcka_in(sdcka_in),
        .sdckb_in(sdckb_in), .tx_start(tx_start), .tx_busy(tx_busy), .line_oe(line_oe),
        .rx_arm(rx_arm), .rx_busy(rx_busy), .rx_done(rx_done), .busy(busy), .done(done),
        .status(status)
`ifdef MAPLE_LINK_STATS_EN
        , .stat_clr(stat_clr), .stat_ok(stat_ok), .stat_timeout(stat_timeout), .stat_abort(stat_abort)
`endif
    );

    always #5 aclk = ~aclk;

    int vectors = 0, miscompares = 0, cyc = 0;
    int t_txs = -1, t_oe_last = -1, t_arm = -1, t_done = -1;
    int n_txs = 0, n_arm = 0, n_done = 0;
    logic [1:0] d_status;
    logic d_oe, d_arm, prev_arm = 1'b0;
    bit rx_live = 1'b0;
    // Peripheral behaviour: transmitter busy window and receiver response relative to rx_arm
    int tx_L = -1000, cfg_td = 1, cfg_len = 0, cfg_D = 0, cfg_B = 2;
    bit cfg_rxd = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
`ifdef MAPLE_LINK_STATS_EN
        bit rst_or_clr;
        rst_or_clr = areset || stat_clr;
`endif
        @(posedge aclk);
        #1;
        cyc++;
        if (tx_start) begin t_txs = cyc; n_txs++; tx_L = cyc; end
        if (line_oe) t_oe_last = cyc;
        if (rx_arm && !prev_arm) begin t_arm = cyc; rx_live = 1'b1; end
        if (!rx_arm) rx_live = 1'b0;
        if (rx_arm) n_arm++;
        prev_arm = rx_arm;
        if (done) begin
            t_done = cyc; d_status = status; d_oe = line_oe; d_arm = rx_arm; n_done++;
        end
`ifdef MAPLE_LINK_STATS_EN
        if (rst_or_clr) begin e_ok = 0; e_to = 0; e_ab = 0; end
        if (done) begin
            if (status == 2'b00) e_ok++;
            if (status == 2'b01) e_to++;
            if (status == 2'b11) e_ab++;
        end
`endif
        chk("oe_arm_exclusive", 64'(line_oe & rx_arm), 64'd0);
        tx_busy = (cyc >= tx_L + cfg_td) && (cyc < tx_L + cfg_td + cfg_len);
        rx_busy = rx_live && (cyc >= t_arm + cfg_D) && (cyc < t_arm + cfg_D + cfg_B);
        rx_done = rx_live && cfg_rxd && (cyc == t_arm + cfg_D + cfg_B - 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_start"}, 64'(tx_start), 64'd0);
        chk({tag, "_line_oe"},  64'(line_oe),  64'd0);
        chk({tag, "_rx_arm"},   64'(rx_arm),   64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_status"},   64'(status),   64'd0);
    endtask

    // One transaction: expected event cycles follow from the guard, TX window, turnaround and RX rules.
    task automatic run_txn(input bit rx_exp, input int T, input int td, input int txlen,
                           input int D, input int B, input bit rxd, input int low_at,
                           input int low_len, input int abort_off, input bit keep);
        int s, gs, L, exp_txs, exp_oe, exp_arm, exp_done, budget, n_arm0;
        logic [1:0] exp_st;
        bit tx_ok, arm_exp;
        rx_expect = rx_exp; timeout_cycles = TW'(T);
        cfg_td = td; cfg_len = txlen; cfg_D = D; cfg_B = B; cfg_rxd = rxd;
        ctrl_enable = 1'b1; frame_avail = 1'b1;
        t_txs = -1; t_arm = -1; t_done = -1; t_oe_last = -1; n_arm0 = n_arm;
        s = cyc; gs = s + 1;
        budget = GUARD + low_at + low_len + txlen + td + TURN + T + D + B + 100;
        for (int k = 0; k < budget && t_done < 0; k++) begin
            step();
            if (t_txs >= 0 && !keep) frame_avail = 1'b0;
            sdckb_in = !(low_at >= 0 && cyc >= gs + low_at && cyc < gs + low_at + low_len);
            if (abort_off >= 0 && t_arm >= 0 && cyc == t_arm + D + abort_off) ctrl_enable = 1'b0;
        end
        chk("done_within_budget", 64'(t_done >= 0), 64'd1);
        exp_txs = (low_at >= 0) ? gs + low_at + low_len + GUARD : gs + GUARD;
        chk("tx_start_cycle", t_txs, exp_txs);
        L = t_txs;
        tx_ok = (txlen > 0) && (td <= 8);
        exp_arm = 0;
        arm_exp = 1'b0;
        if (!tx_ok) begin
            exp_oe = L + 8; exp_done = L + 9; exp_st = 2'b11;
        end else begin
            exp_oe = L + td + txlen;
            exp_arm = exp_oe + TURN + 1;
            arm_exp = rx_exp;
            if (!rx_exp) begin
                exp_done = exp_arm; exp_st = 2'b10;
            end else if (T == 0) begin
                exp_done = exp_arm + 1; exp_st = 2'b01;
            end else if (D <= T - 1) begin
                if (abort_off >= 0) begin exp_done = exp_arm + D + abort_off + 1; exp_st = 2'b11; end
                else if (rxd)       begin exp_done = exp_arm + D + B;             exp_st = 2'b00; end
                else                begin exp_done = exp_arm + D + B + 1;         exp_st = 2'b01; end
            end else begin
                exp_done = exp_arm + T; exp_st = 2'b01;
            end
        end
        chk("line_oe_last_cycle", t_oe_last, exp_oe);
        if (arm_exp) chk("rx_arm_rise_cycle", t_arm, exp_arm);
        else         chk("rx_arm_never", n_arm - n_arm0, 0);
        chk("done_cycle", t_done, exp_done);
        chk("done_status", 64'(d_status), 64'(exp_st));
        chk("done_line_oe", 64'(d_oe), 64'd0);
        chk("done_rx_arm", 64'(d_arm), 64'd0);
        ctrl_enable = 1'b1;
        step();
        chk("post_done_pulse", 64'(done), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_rx_arm", 64'(rx_arm), 64'd0);
    endtask

    initial begin
        int first_done, n0, nd;
        areset = 1'b1; ctrl_enable = 1'b0; frame_avail = 1'b0; rx_expect = 1'b0;
        timeout_cycles = '0; sdcka_in = 1'b1; sdckb_in = 1'b1;
        tx_busy = 1'b0; rx_busy = 1'b0; rx_done = 1'b0;
`ifdef MAPLE_LINK_STATS_EN
        stat_clr = 1'b0;
`endif
        step(); step();
        chk_all_zero("reset");
        areset = 1'b0;
        step();

        // Guard/turnaround timing, guard restart, timeout, TX-only, abort in RX
        run_txn(1, 1000, 1, 200, 50, 10, 1, -1, 0, -1, 0);
        run_txn(1, 1000, 1, 20, 10, 5, 1, 40, 7, -1, 0);
        run_txn(1, 100, 1, 20, 1000, 5, 1, -1, 0, -1, 0);
        run_txn(0, 100, 2, 15, 5, 5, 1, -1, 0, -1, 0);
        run_txn(1, 1000, 1, 20, 5, 40, 1, -1, 0, 3, 0);
        // Boundaries: TX start window, zero timeout, response at last/after-last count, rx_busy drop
        run_txn(1, 200, 8, 10, 5, 4, 1, -1, 0, -1, 0);
        run_txn(1, 200, 9, 10, 5, 4, 1, -1, 0, -1, 0);
        run_txn(1, 200, 1, 0, 5, 4, 1, -1, 0, -1, 0);
        run_txn(1, 0, 1, 5, 3, 4, 1, -1, 0, -1, 0);
        run_txn(1, 30, 1, 5, 29, 4, 1, -1, 0, -1, 0);
        run_txn(1, 30, 1, 5, 30, 4, 1, -1, 0, -1, 0);
        run_txn(1, 300, 1, 5, 12, 6, 0, -1, 0, -1, 0);

        // Enable dropped during GUARD: silent return to IDLE
        n0 = n_txs; nd = n_done;
        ctrl_enable = 1'b1; frame_avail = 1'b1;
        repeat (20) step();
        ctrl_enable = 1'b0;
        repeat (100) step();
        chk("guard_abort_no_tx_start", n_txs - n0, 0);
        chk("guard_abort_no_done", n_done - nd, 0);
        frame_avail = 1'b0; ctrl_enable = 1'b1;
        step();

        // Reset in the middle of TX
        cfg_td = 1; cfg_len = 50; rx_expect = 1'b0; frame_avail = 1'b1; t_txs = -1;
        for (int k = 0; k < 200 && t_txs < 0; k++) step();
        chk("midtx_tx_started", 64'(t_txs >= 0), 64'd1);
        frame_avail = 1'b0;
        repeat (3) step();
        chk("midtx_line_oe", 64'(line_oe), 64'd1);
        areset = 1'b1;
        step();
        chk_all_zero("midtx_reset");
        areset = 1'b0; tx_L = -1000;
        repeat (2) step();

        // Back-to-back frames
        nd = n_done;
        run_txn(0, 0, 1, 10, 1, 2, 0, -1, 0, -1, 1);
        first_done = t_done;
        run_txn(0, 0, 1, 10, 1, 2, 0, -1, 0, -1, 0);
        chk("b2b_second_tx_start", t_txs, first_done + 2 + GUARD);
        chk("b2b_two_done", n_done - nd, 2);

        // Randomized transactions
        for (int i = 0; i < 10; i++) begin
            int T, td, txlen, D, B;
            bit rx_exp, rxd;
            rx_exp = ($urandom_range(0, 3) != 0);
            T      = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 200));
            td     = $urandom_range(1, 9);
            txlen  = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 30));
            D      = $urandom_range(1, 220);
            B      = $urandom_range(2, 15);
            rxd    = $urandom_range(0, 1);
            run_txn(rx_exp, T, td, txlen, D, B, rxd, -1, 0, -1, 0);
        end

`ifdef MAPLE_LINK_STATS_EN
        chk("stat_ok", 64'(stat_ok), 64'(e_ok));
        chk("stat_timeout", 64'(stat_timeout), 64'(e_to));
        chk("stat_abort", 64'(stat_abort), 64'(e_ab));
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("stat_clr_ok", 64'(stat_ok), 64'd0);
        chk("stat_clr_timeout", 64'(stat_timeout), 64'd0);
        chk("stat_clr_abort", 64'(stat_abort), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/maple_link_ctrl.md
Name: maple_link_ctrl

Overview:
- Transaction sequencer for the Maple Bus PHY; owns the direction of the shared sdcka/sdckb lines.
- Sequence: bus-idle guard, TX frame, line turnaround, RX window with timeout, status report.
- Sits between the TX/RX AXIS FIFOs, the transmitter and receiver engines, and the AXI-Lite control registers.
- Replaces the direct FIFO-tvalid enable of the transmitter and ensures TX and RX never contend for the lines.

Parameters:
- GUARD_CYCLES, 64: consecutive cycles both lines must read high before a TX may start.
- TURN_CYCLES, 16: cycles line_oe stays low after the TX ends, before the RX is armed.
- TIMEOUT_W, 20: width of the response timeout counter and of timeout_cycles.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- ctrl_enable  in  1  block enable from the control register
- frame_avail  in  1  TX FIFO holds at least one complete (tlast-terminated) frame
- rx_expect  in  1  a response is expected; sampled at tx_start
- timeout_cycles  in  TIMEOUT_W  response timeout; sampled at tx_start
- sdcka_in  in  1  sensed line A
- sdckb_in  in  1  sensed line B
- tx_start  out  1  one-cycle pulse that launches the transmitter
- tx_busy  in  1  transmitter active (start pattern through end pattern)
- line_oe  out  1  1 = PHY drives the lines, 0 = lines released/tristated
- rx_arm  out  1  receiver may detect a start pattern
- rx_busy  in  1  receiver is mid-frame
- rx_done  in  1  one-cycle pulse: end pattern received
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- status  out  2  00 ok, 01 timeout, 10 tx-only, 11 aborted; held until the next done

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- Same-cycle priority: areset > ctrl_enable low > state logic.
- IDLE: line_oe=0, busy=0. Go to GUARD when ctrl_enable && frame_avail.
- GUARD:
  - guard counter increments while sdcka_in && sdckb_in; clears to 0 on any low sample.
  - When the count reaches GUARD_CYCLES-1 with both lines high, go to LAUNCH.
  - If ctrl_enable falls, go to IDLE with no done pulse.
- LAUNCH (one cycle):
  - line_oe=1, tx_start=1, busy=1.
  - Latch rx_expect and timeout_cycles.
  - Go to TX.
- TX:
  - line_oe=1.
  - Wait for the tx_busy falling edge (tx_busy seen high, then low).
  - If tx_busy never rises within 8 cycles of tx_start, go to DONE with status 11.
- TURN:
  - line_oe=0; count TURN_CYCLES cycles.
  - Then go to RX_WAIT if the latched rx_expect is 1, otherwise to DONE with status 10.
- RX_WAIT:
  - rx_arm=1; the timeout counter counts up from 0.
  - rx_busy=1 → RX; the timeout counter freezes.
  - Count == latched timeout_cycles-1 with rx_busy=0 → DONE with status 01.
  - Latched timeout_cycles = 0 means an immediate timeout on the first RX_WAIT cycle.
  - rx_busy and expiry in the same cycle: rx_busy wins.
- RX:
  - rx_arm=1.
  - rx_done → DONE with status 00.
  - rx_busy falling without rx_done → DONE with status 01.
- DONE (one cycle): done=1, status updated, busy=0 on the next cycle, return to IDLE.
- A frame_avail still high in IDLE starts a new GUARD on the next cycle, giving back-to-back transactions.
- ctrl_enable low in LAUNCH, TX, TURN, RX_WAIT or RX:
  - Next state is DONE with status 11; line_oe and rx_arm drop to 0 that same next cycle.
  - The transmitter is not aborted by this block.
- line_oe and rx_arm are never 1 in the same cycle; asserting both is a design error.
- Counters saturate and never wrap.

Optional Feature:
- Macro: MAPLE_LINK_STATS_EN.
- Defined:
  - Adds outputs stat_ok, stat_timeout and stat_abort, each 16 bits.
  - Each counts DONE events with status 00, 01 and 11 respectively, saturating at 0xFFFF.
  - Input stat_clr (1 bit) zeroes all three counters; a DONE in the same cycle is lost.
  - areset clears all three counters.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Guard and turnaround timing:
  - Stimulus: GUARD_CYCLES=64, TURN_CYCLES=16, lines high, frame_avail=1, rx_expect=1, timeout 1000; model tx_busy for 200 cycles, rx_busy 50 cycles after arm, rx_done.
  - Required: tx_start exactly 64 cycles after entering GUARD; line_oe=0 for exactly 16 cycles before rx_arm; done with status 00.
- Guard reset:
  - Stimulus: sdckb_in pulled low at guard count 40.
  - Required: count restarts; tx_start comes 64 cycles after the line returns high.
- Response timeout:
  - Stimulus: rx_expect=1, timeout_cycles=100, rx_busy never asserted.
  - Required: done exactly 100 cycles after rx_arm rises; status 01; rx_arm low afterwards.
- TX-only transaction:
  - Stimulus: rx_expect=0.
  - Required: status 10; rx_arm never asserted.
- Abort mid-RX:
  - Stimulus: ctrl_enable dropped during RX.
  - Required: status 11 next cycle; line_oe=0 and rx_arm=0.
- Reset and back-to-back:
  - Stimulus: areset asserted mid-TX.
  - Required: all outputs 0 next cycle.
  - Stimulus: two queued frames.
  - Required: two done pulses, with the second GUARD starting immediately after the first DONE.
